// File: rtl/instr_mem_loader.sv
// Serial program loader: parses a length-prefixed little-endian byte stream
// into 32-bit words and writes them into instruction memory while holding the core in reset.
module instr_mem_loader #(
   parameter int MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   output logic        cpu_rst,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_LO = 3'd1,
      LEN_HI = 3'd2,
      DATA   = 3'd3,
      WRITE  = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } state_t;

   localparam logic [16:0] MAX_W = 17'(MEM_WORDS);

   state_t      state, state_nxt;
   logic [15:0] n_words;
   logic [15:0] idx;
   logic [1:0]  bcnt;
   logic [31:0] asm_word;
   logic        accept;
   logic [15:0] len_full;
   logic        last_word;

   // Everything visible outside is a pure decode of the state register, so
   // byte_valid never reaches byte_ready combinationally.
   assign byte_ready = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
   assign busy       = byte_ready || (state == WRITE);
   assign mem_we     = (state == WRITE);
   assign mem_addr   = (state == WRITE) ? {14'd0, idx, 2'b00} : 32'd0;
   assign mem_wd     = (state == WRITE) ? asm_word : 32'd0;
   assign done       = (state == DONE);
   assign error      = (state == ERR);
   assign cpu_rst    = (state != DONE);

   assign accept    = byte_valid && byte_ready;
   assign len_full  = {byte_in, n_words[7:0]};
   assign last_word = ({1'b0, idx} + 17'd1) == {1'b0, n_words};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERR: if (start) state_nxt = LEN_LO;
         LEN_LO: if (accept) state_nxt = LEN_HI;
         LEN_HI: begin
            if (accept) begin
               if (len_full == 16'd0)              state_nxt = DONE;
               else if ({1'b0, len_full} > MAX_W)  state_nxt = ERR;
               else                                state_nxt = DATA;
            end
         end
         DATA:    if (accept && bcnt == 2'd3) state_nxt = WRITE;
         WRITE:   state_nxt = last_word ? DONE : DATA;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_words  <= 16'd0;
         idx      <= 16'd0;
         bcnt     <= 2'd0;
         asm_word <= 32'd0;
      end else begin
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  n_words <= 16'd0;
                  idx     <= 16'd0;
                  bcnt    <= 2'd0;
               end
            end
            LEN_LO: if (accept) n_words[7:0] <= byte_in;
            LEN_HI: begin
               if (accept) begin
                  n_words[15:8] <= byte_in;
                  idx           <= 16'd0;
                  bcnt          <= 2'd0;
               end
            end
            DATA: begin
               if (accept) begin
                  asm_word[{bcnt, 3'b000} +: 8] <= byte_in;
                  bcnt                          <= bcnt + 2'd1;
               end
            end
            WRITE:   idx <= idx + 16'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter MEM_WORDS, default 64, instruction memory depth in 32-bit words; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a load; sampled only in IDLE, DONE or ERR.
REQ-005 byte_in  input  8  serial program byte.
REQ-006 byte_valid  input  1  byte_in valid.
REQ-007 byte_ready  output  1  loader can accept a byte; a transfer occurs on an edge where byte_valid && byte_ready.
REQ-008 mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
REQ-009 mem_addr  output  32  byte address of the word being written (word index * 4).
REQ-010 mem_wd  output  32  word to write.
REQ-011 cpu_rst  output  1  holds the core in reset while it is high.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  load completed successfully.
REQ-014 error  output  1  load rejected.

Function
REQ-015 Stream format: 16-bit word count N, little-endian (2 bytes), followed by N words, 4 bytes each, little-endian.
REQ-016 FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
REQ-017 IDLE: byte_ready=0, cpu_rst=1; start -> LEN_LO.
REQ-018 LEN_LO: byte_ready=1; an accepted byte becomes N[7:0] -> LEN_HI.
REQ-019 LEN_HI: byte_ready=1; an accepted byte becomes N[15:8]. Next state: N==0 -> DONE; N>MEM_WORDS -> ERR; otherwise DATA, with word index=0 and byte count=0.
REQ-020 DATA: byte_ready=1; accepted byte k (0..3) goes to bits [8k+7:8k] of the assembly register. After the 4th byte -> WRITE.
REQ-021 WRITE lasts exactly one cycle, with byte_ready=0, mem_we=1, mem_addr=index*4, mem_wd=assembled word. Index increments at the end of the cycle. Next state: index+1==N -> DONE, else DATA.
REQ-022 Cycles with byte_valid=0 change no state; stalls of any length are legal.
REQ-023 mem_we is never asserted outside WRITE; exactly N writes per successful load, at addresses 0,4,...,4(N-1), in order.
REQ-024 DONE: done=1, cpu_rst=0, busy=0, byte_ready=0; holds until start or rst.
REQ-025 ERR: error=1, cpu_rst=1, busy=0, byte_ready=0; no writes; holds until start or rst.
REQ-026 start in DONE or ERR -> LEN_LO. In that same edge done and error clear and cpu_rst returns to 1.
REQ-027 busy=1 in LEN_LO, LEN_HI, DATA and WRITE.
REQ-028 start while busy is ignored.
REQ-029 byte_in is ignored whenever byte_ready=0.
REQ-030 Outputs are registered or decoded from state only; no combinational path from byte_valid to byte_ready.

Reset
REQ-031 While rst=1, the block is forced asynchronously into IDLE: byte_ready=0, mem_we=0, mem_addr=0, mem_wd=0, cpu_rst=1, busy=0, done=0, error=0; N, index and byte count are zero.
REQ-032 rst in any state, including mid-word in DATA or in WRITE, aborts the load. The pending write does not occur, and after release the block waits in IDLE for start.

Verification
REQ-033 Reset: pulse rst for 2 time units at time 2 -> all outputs at their REQ-031 values within the same time step; the values persist with no start.
REQ-034 Three-word load: start, then bytes 03 00 | 63 18 40 00 | 63 14 42 00 | e3 16 52 fe, byte_valid held high. Required response:
  - mem_we pulses at mem_addr 0, 4, 8 with mem_wd 32'h00401863, 32'h00421463, 32'hfe5216e3;
  - byte_ready is low during each write cycle;
  - done=1 and cpu_rst=0 on the edge after the 3rd write.
REQ-035 Zero length: start, then bytes 00 00 -> DONE on the edge accepting the 2nd byte; no mem_we; cpu_rst=0.
REQ-036 Oversize: MEM_WORDS=64, start, then bytes 41 00 (N=65) -> error=1, cpu_rst=1, byte_ready=0, no mem_we. A following start returns the block to LEN_LO with error=0.
REQ-037 Stalls: the REQ-034 stream with byte_valid low for 3 cycles between every byte -> identical write addresses and data; write count stays 3.
REQ-038 Reset mid-load: assert rst after byte 2 of word 1 in the REQ-034 stream -> mem_we stays 0 from then on, state is IDLE, cpu_rst=1, done=0; a full reload afterwards succeeds as in REQ-034.
